// File: rtl/conv_mac_0_pkg.sv
// Shared widths and defaults for the layer-0 convolution MAC and its helpers.
package conv_mac_0_pkg;

    localparam int COEFF_WIDTH   = 16;
    localparam int DATA_WIDTH    = 16;
    localparam int KERN_S_0      = 9;
    localparam int SHIFT_DEFAULT = 8;

    // Accumulator wide enough to sum kern_s full-width products without overflow.
    function automatic int acc_width(input int coeff_w, input int data_w, input int kern_s);
        return coeff_w + data_w + $clog2(kern_s);
    endfunction

endpackage

// File: rtl/conv_mac_0_mac_sat_round.sv
// Combinational rescale: round-half-up arithmetic shift, saturate to DATA_W, optional ReLU.
module mac_sat_round #(
    parameter int ACC_W  = 36,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 8,
    parameter int RELU   = 0
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] res_o
);

    // One guard bit so the rounding bias can never wrap the accumulator.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HALF_C = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAX_C  = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_C  = ~MAX_C;

    logic signed [EXT_W-1:0]  biased_s;
    logic signed [EXT_W-1:0]  shifted_s;
    logic signed [DATA_W-1:0] sat_s;

    // Round, clamp to the result range, then apply the optional ReLU.
    always_comb begin
        biased_s  = {acc_i[ACC_W-1], acc_i} + HALF_C;
        shifted_s = biased_s >>> SHIFT;
        if (shifted_s > MAX_C) begin
            sat_s = MAX_C[DATA_W-1:0];
        end else if (shifted_s < MIN_C) begin
            sat_s = MIN_C[DATA_W-1:0];
        end else begin
            sat_s = shifted_s[DATA_W-1:0];
        end
        if ((RELU != 0) && sat_s[DATA_W-1]) begin
            res_o = '0;
        end else begin
            res_o = sat_s;
        end
    end

endmodule

// File: rtl/conv_mac_0.sv
// Layer-0 convolution MAC: pairs weight/pixel FIFO words, accumulates one kernel
// window, rescales the sum and pushes one result per window to the output FIFO.
module conv_mac_0
    import conv_mac_0_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int KERN_S  = KERN_S_0,
    parameter int SHIFT   = SHIFT_DEFAULT,
    parameter int RELU    = 0
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [COEFF_W-1:0] weight_V_dout,
    input  logic               weight_V_empty_n,
    output logic               weight_V_read,
    input  logic [DATA_W-1:0]  pixel_V_dout,
    input  logic               pixel_V_empty_n,
    output logic               pixel_V_read,
    output logic [DATA_W-1:0]  output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int ACC_W  = acc_width(COEFF_W, DATA_W, KERN_S);
    localparam int PROD_W = COEFF_W + DATA_W;
    localparam int TAP_W  = $clog2(KERN_S);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERN_S - 1);
    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

    logic [TAP_W-1:0]         tap_q, tap_d;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic                     p_valid_q, p_valid_d;
    logic                     p_first_q, p_first_d;
    logic                     p_last_q, p_last_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic signed [DATA_W-1:0] post_s;
    logic                     out_valid_q, out_valid_d;
    logic                     pop_s;
    logic                     write_s;
    logic                     load_s;

    // Handshake: both inputs are always consumed as a pair; a stalled result blocks pops.
    always_comb begin
        write_s = out_valid_q & output_V_full_n;
        pop_s   = weight_V_empty_n & pixel_V_empty_n
                & ~(out_valid_q & ~output_V_full_n) & ~ap_rst;
    end

    // Product stage: multiply the popped pair and tag window start/end.
    always_comb begin
        tap_d     = tap_q;
        p_d       = p_q;
        p_first_d = p_first_q;
        p_last_d  = p_last_q;
        p_valid_d = 1'b0;
        if (pop_s) begin
            p_d       = PROD_W'($signed(weight_V_dout)) * PROD_W'($signed(pixel_V_dout));
            p_valid_d = 1'b1;
            p_first_d = (tap_q == '0);
            p_last_d  = (tap_q == LAST_TAP);
            if (tap_q == LAST_TAP) begin
                tap_d = '0;
            end else begin
                tap_d = tap_q + TAP_ONE;
            end
        end else begin
            p_valid_d = 1'b0;
        end
    end

    // Accumulate stage: the first tap restarts the sum instead of adding to the old one.
    always_comb begin
        acc_sum_s = (p_first_q ? '0 : acc_q) + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
        load_s    = p_valid_q & p_last_q;
        acc_d     = acc_q;
        if (p_valid_q) begin
            acc_d = acc_sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    mac_sat_round #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_sat (
        .acc_i(acc_sum_s),
        .res_o(post_s)
    );

    // Output register: a fresh result keeps out_valid set even if the old one leaves now.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load_s) begin
            out_d       = post_s;
            out_valid_d = 1'b1;
        end else if (write_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tap_q       <= '0;
            p_q         <= '0;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            tap_q       <= tap_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign weight_V_read  = pop_s;
    assign pixel_V_read   = pop_s;
    assign output_V_din   = out_q;
    assign output_V_write = write_s;

endmodule

// File: doc/conv_mac_0.md
Name: conv_mac_0

Overview:
- Downstream consumer of the layer-0 weight streamer. Pairs each coefficient from the weight FIFO stream with a pixel from the activation FIFO stream.
- Accumulates `kern_s_0 products per output point, then rescales, rounds, saturates and optionally applies ReLU.
- Pushes one result per kernel window into the next layer's FIFO.
- All three streams use the ap_fifo handshake (dout/empty_n/read in, din/full_n/write out).

Parameters:
- COEFF_W, `coeff_width, signed coefficient width
- DATA_W, `data_width, signed pixel and result width
- KERN_S, `kern_s_0, taps per window; must be ≥2
- SHIFT, 8, fractional bits of coefficient; right-shift applied to accumulator
- RELU, 0, 1 = clamp negative results to 0
- ACC_W, COEFF_W+DATA_W+$clog2(KERN_S), accumulator width (derived, not overridden)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  reset, asynchronous, active-high
- weight_V_dout  in  COEFF_W  coefficient, first-word-fall-through
- weight_V_empty_n  in  1  coefficient available
- weight_V_read  out  1  pop coefficient
- pixel_V_dout  in  DATA_W  pixel, first-word-fall-through
- pixel_V_empty_n  in  1  pixel available
- pixel_V_read  out  1  pop pixel
- output_V_din  out  DATA_W  result
- output_V_full_n  in  1  output FIFO has space
- output_V_write  out  1  push result

Behaviour:
- Clocking and reset:
  - Single clock, ap_clk.
  - ap_rst is asynchronous and active-high. It clears tap counter, p_valid, p_last, accumulator, out_reg and out_valid.
  - Reset mid-window discards the partial sum. The first pair popped after reset is tap 0.
- Outputs during and after reset: weight_V_read=0, pixel_V_read=0, output_V_write=0, output_V_din=0.
- Pop rule:
  - pop = weight_V_empty_n & pixel_V_empty_n & ~(out_valid & ~output_V_full_n).
  - weight_V_read = pixel_V_read = pop. Both streams are always consumed as a pair; never one without the other.
- Stage P, on pop:
  - p_reg <= signed(weight) * signed(pixel), full COEFF_W+DATA_W product.
  - p_valid <= 1; p_first <= (tap==0); p_last <= (tap==KERN_S-1).
  - tap increments, wrapping KERN_S-1 -> 0.
  - No pop: p_valid <= 0.
- Stage A, when p_valid:
  - acc <= (p_first ? 0 : acc) + sign-extended p_reg.
  - If p_last also: out_reg <= post(acc_next), out_valid <= 1.
- post(x):
  - r = (x + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round-half-up.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If RELU, negative results become 0.
- Output handshake:
  - output_V_din = out_reg.
  - output_V_write = out_valid & output_V_full_n.
  - When a write happens and no new result lands that cycle, out_valid <= 0.
  - A write and a new out_reg load may coincide; out_valid then stays 1.
- Latency: last pair popped in cycle t -> output_V_write may assert in cycle t+2.
- Throughput: 1 pair/cycle with no bubbles; one result every KERN_S cycles.
- Backpressure:
  - While out_valid=1 and full_n=0: no pops, and out_reg/output_V_din hold stable.
  - KERN_S≥2 guarantees stage A never finds out_reg occupied and unwritable.
- Input bubbles: if either input is empty, neither FIFO is read; the tap counter and accumulator hold.
- Overflow: ACC_W guarantees no accumulator overflow for any inputs.

Decomposition:
- Shared package / include:
  - data_width and coeff_width, added to my_types.vh.
  - kern_s_0, already in layers_sizes.vh.
  - Accumulator-width macro; SHIFT default constant.
- One natural sub-module: mac_sat_round, combinational round/saturate/ReLU, parameterised by ACC_W, DATA_W, SHIFT, RELU. It is reused by later conv layers.

Test Plan:
- Basic window: KERN_S=9, SHIFT=8, weights all 256, pixels 1..9, full_n=1.
  - Required: exactly one write, din=45, two cycles after the 9th read.
- Saturation: weights 0x7FFF, pixels 0x7FFF (DATA_W=COEFF_W=16) -> din=0x7FFF. Weights 0x7FFF, pixels 0x8000 -> din=0x8000 (RELU=0).
- ReLU: RELU=1, weights 256, pixels all -3 -> din=0. Pixels all +3 -> din=27.
- Backpressure: full_n=0 when out_valid rises.
  - Required: write=0, din held, reads=0 for the whole stall.
  - full_n=1 -> one write that cycle, reads resume the same cycle.
- Pairing and bubbles: toggle weight_empty_n randomly with pixels always available.
  - Required: pixel_V_read never asserts without weight_V_read; results match the golden model.
- Reset mid-window: assert ap_rst after 4 taps, then feed a full window of weight 256 / pixel 2.
  - Required: din=18. All outputs 0 during reset.
- Streaming: 3 back-to-back windows with no bubbles.
  - Required: reads continuous; writes at 9-cycle spacing; values correct.
